// File: rtl/rmw_update_initiator_if.sv
// Command, memory and completion signals of the read-modify-write initiator.
// master = the initiator itself; slave = command producer, RAM and observers.
interface rmw_update_initiator_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_inc;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              done_valid;
    logic [DATA_W-1:0] done_data;
    logic [CNT_W-1:0]  count;

    modport master (
        input  cmd_valid, cmd_addr, cmd_inc, mem_rdata,
        output cmd_ready, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               done_valid, done_data, count
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_inc, mem_rdata,
        input  cmd_ready, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
               done_valid, done_data, count
    );
endinterface

// File: rtl/rmw_update_initiator.sv
// Two-stage read-modify-write initiator: read on accept, add and write back one
// cycle later, forwarding the in-flight sum to a back-to-back same-address command.
module rmw_update_initiator #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    rmw_update_initiator_if.master io
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              fire;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_inc;
    logic              fwd;
    logic [DATA_W-1:0] s1_prev_wdata;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] sum;
    logic              hit;
    logic [CNT_W-1:0]  count;

    assign io.cmd_ready = ~reset;
    assign fire         = io.cmd_valid & io.cmd_ready;

    assign io.mem_ren   = fire;
    assign io.mem_raddr = io.cmd_addr;

    // The RAM returns pre-write data when the previous command is writing the
    // same word this cycle, so that command's sum is used instead.
    assign operand = fwd ? s1_prev_wdata : io.mem_rdata;
    assign sum     = operand + s1_inc;
    assign hit     = fire & s1_valid & (s1_addr == io.cmd_addr);

    // s1_valid clears asynchronously, so an in-flight write is dropped at once.
    assign io.mem_wen    = s1_valid;
    assign io.mem_waddr  = s1_valid ? s1_addr : '0;
    assign io.mem_wdata  = s1_valid ? sum : '0;
    assign io.done_valid = s1_valid;
    assign io.done_data  = s1_valid ? sum : '0;
    assign io.count      = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            s1_inc        <= '0;
            fwd           <= 1'b0;
            s1_prev_wdata <= '0;
            count         <= '0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_addr <= io.cmd_addr;
                s1_inc  <= io.cmd_inc;
            end
            fwd <= hit;
            if (hit) begin
                s1_prev_wdata <= sum;
            end
            if (s1_valid && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rmw_update_initiator.sv
// Randomised scoreboard bench: the stimulus side keeps a word-array model of the
// RAM contents, a monitor checks every completion, write and counter value.
module tb_rmw_update_initiator;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] inc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rmw_update_initiator_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) io();

    rmw_update_initiator #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (rst),
        .io    (io.master)
    );

    // Synchronous-read, read-before-write RAM plus a preload port for the bench.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (io.mem_ren) rdata_q <= mem[io.mem_raddr];
        if (io.mem_wen) mem[io.mem_waddr] <= io.mem_wdata;
        if (pre_en) mem[pre_addr] <= pre_data;
    end
    assign io.mem_rdata = rdata_q;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          q [$];
    int            checks = 0;
    int            errors = 0;
    int unsigned   mcount = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmd(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] inc);
        bit   fire;
        exp_t e;
        io.cmd_valid = v;
        io.cmd_addr  = a;
        io.cmd_inc   = inc;
        #1;
        fire = v && (io.cmd_ready === 1'b1);
        chk("mem_ren", {63'd0, io.mem_ren}, {63'd0, fire});
        if (fire) chk("mem_raddr", {61'd0, io.mem_raddr}, {61'd0, a});
        @(posedge clk);
        if (fire) begin
            e.addr = a;
            e.inc  = inc;
            e.data = ref_mem[a] + inc;
            ref_mem[a] = e.data;
            q.push_back(e);
        end
        #1;
        io.cmd_valid = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Reset asserted right after an accept edge: the pending update never lands.
    task automatic assert_reset();
        exp_t e;
        rst = 1'b1;
        if (q.size() != 0) begin
            e = q.pop_back();
            ref_mem[e.addr] = e.data - e.inc;
        end
        q.delete();
        mcount = 0;
        #1;
        chk("rst_wen", {63'd0, io.mem_wen}, 64'd0);
        chk("rst_done_valid", {63'd0, io.done_valid}, 64'd0);
        chk("rst_ready", {63'd0, io.cmd_ready}, 64'd0);
        chk("rst_count", {48'd0, io.count}, 64'd0);
    endtask

    // Monitor: every negedge, one completion per accepted command, in order.
    always @(negedge clk) begin
        exp_t e;
        if (io.done_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0h required=none", io.done_data);
            end else begin
                e = q.pop_front();
                chk("done_data", {32'd0, io.done_data}, {32'd0, e.data});
                chk("mem_wdata", {32'd0, io.mem_wdata}, {32'd0, e.data});
                chk("mem_waddr", {61'd0, io.mem_waddr}, {61'd0, e.addr});
                chk("mem_wen", {63'd0, io.mem_wen}, 64'd1);
            end
        end else begin
            if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_done actual=idle required=%0h", q[0].data);
                q.delete();
            end
            chk("idle_wen", {63'd0, io.mem_wen}, 64'd0);
            chk("idle_wdata", {32'd0, io.mem_wdata}, 64'd0);
            chk("idle_done_data", {32'd0, io.done_data}, 64'd0);
        end
        chk("count", {48'd0, io.count}, {32'd0, mcount});
        if (io.done_valid === 1'b1 && mcount != 32'hFFFF) mcount = mcount + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v4;
        io.cmd_valid = 1'b0;
        io.cmd_addr  = '0;
        io.cmd_inc   = '0;
        @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, io.cmd_ready}, 64'd0);
        chk("reset_wen", {63'd0, io.mem_wen}, 64'd0);
        chk("reset_done", {63'd0, io.done_valid}, 64'd0);
        chk("reset_count", {48'd0, io.count}, 64'd0);
        for (int i = 0; i < DEPTH; i++) preload(AW'(i), '0);
        rst = 1'b0;
        cmd(0, '0, '0);

        // single update from zeroed memory
        cmd(1, 3'd3, 32'd1);
        cmd(0, '0, '0);
        // back-to-back same-address chain
        preload(3'd5, 32'd10);
        repeat (3) cmd(1, 3'd5, 32'd1);
        cmd(0, '0, '0);
        // interleaved addresses, third re-reads updated memory
        preload(3'd1, 32'd100);
        preload(3'd2, 32'd200);
        cmd(1, 3'd1, 32'd1);
        cmd(1, 3'd2, 32'd1);
        cmd(1, 3'd1, 32'd1);
        cmd(0, '0, '0);
        // wraparound
        preload(3'd7, 32'hFFFF_FFFF);
        cmd(1, 3'd7, 32'd1);
        cmd(0, '0, '0);

        // reset with a forwarded update in flight
        preload(3'd4, 32'd50);
        cmd(1, 3'd4, 32'd7);
        cmd(1, 3'd4, 32'd9);
        v4 = ref_mem[4] - 32'd9;
        assert_reset();
        cmd(0, '0, '0);
        cmd(0, '0, '0);
        chk("rst_mem4_kept", {32'd0, mem[4]}, {32'd0, v4});
        rst = 1'b0;
        cmd(1, 3'd4, 32'd2);
        cmd(0, '0, '0);

        // random traffic, biased toward short same-address chains
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] inc;
            a   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 1)) : AW'($urandom_range(0, DEPTH - 1));
            inc = ($urandom_range(0, 3) == 0) ? $urandom() : DW'($urandom_range(0, 15));
            cmd($urandom_range(0, 3) != 0, a, inc);
        end
        cmd(0, '0, '0);

        // counter saturation
        assert_reset();
        cmd(0, '0, '0);
        rst = 1'b0;
        for (int i = 0; i < 32'hFFFE + 3; i++) begin
            cmd(1, AW'($urandom_range(0, DEPTH - 1)), $urandom());
        end
        cmd(0, '0, '0);
        cmd(0, '0, '0);
        chk("sat_count", {48'd0, io.count}, 64'h0000_0000_0000_FFFF);

        for (int i = 0; i < DEPTH; i++) chk("final_mem", {32'd0, mem[i]}, {32'd0, ref_mem[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
